// File: rtl/pc_pkg.sv
// Shared types for the PC target table.
//   pc_t        default-width program counter / jump target
//   tt_state_e  table controller state: INIT (default-map sweep), RUN (service port)
//   PC_HOLD     target returned on a lookup miss, leaving the PC unchanged
package pc_pkg;

    localparam int unsigned PC_W = 12;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } tt_state_e;

    localparam pc_t PC_HOLD = '0;

endpackage

// File: rtl/pc_tt_init_ctr.sv
// Sweep counter for the table initialisation pass.
//   clk_i      clock
//   rst_ni     asynchronous active-low reset, forces idx to 0
//   restart_i  synchronous return to idx 0
//   en_i       advance one entry per cycle; wraps to 0 after the last entry
//   idx_o      entry being initialised this cycle
//   done_o     idx_o is the last entry
module pc_tt_init_ctr #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IW      = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          restart_i,
    input  logic          en_i,
    output logic [IW-1:0] idx_o,
    output logic          done_o
);

    logic [IW-1:0] idx_q, idx_d;

    assign done_o = (idx_q == IW'(ENTRIES - 1));
    assign idx_o  = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (restart_i) begin
            idx_d = '0;
        end else if (en_i) begin
            // Wrap to 0 so the counter is already parked for the next sweep.
            idx_d = done_o ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/pc_target_table.sv
// Programmable jump-target table between instruction decode and the PC register.
// After reset or clr it sweeps the default map (entry 0 = 0, others = DEF_TARGET),
// one entry per cycle, then serves registered lookups and run-time writes.
//   Clk, Reset                      clock, asynchronous active-low reset
//   lookup_req/lookup_addr          lookup strobe and index
//   target/hit/target_valid         registered lookup result, valid pulses one cycle
//   wr_en/wr_addr/wr_data/wr_ack    write port; ack pulses one cycle per accepted write
//   clr                             restart the default-map sweep
//   busy                            sweep in progress, all requests ignored
module pc_target_table
    import pc_pkg::*;
#(
    parameter int unsigned D          = PC_W,
    parameter int unsigned A          = 8,
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned DEF_TARGET = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         lookup_req,
    input  logic [A-1:0] lookup_addr,
    output logic [D-1:0] target,
    output logic         target_valid,
    output logic         hit,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    output logic         wr_ack,
    input  logic         clr,
    output logic         busy
);

    localparam int unsigned IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    tt_state_e state_q, state_d;

    logic [IW-1:0] idx;
    logic          sweep_done;

    logic         in_run;
    logic         lk_go, lk_hit, wr_go, bypass;
    logic         tbl_we;
    logic [IW-1:0] tbl_widx;
    logic [D-1:0] tbl_wval;
    logic [D-1:0] rd_val;

    logic [D-1:0] target_q;
    logic         target_valid_q, hit_q, wr_ack_q;

    // Table storage: no reset, contents are rebuilt by the sweep.
    logic [D-1:0] tbl [ENTRIES];

    pc_tt_init_ctr #(
        .ENTRIES (ENTRIES),
        .IW      (IW)
    ) u_init_ctr (
        .clk_i     (Clk),
        .rst_ni    (Reset),
        .restart_i (in_run && clr),
        .en_i      (state_q == INIT),
        .idx_o     (idx),
        .done_o    (sweep_done)
    );

    assign in_run = (state_q == RUN);

    // Unsigned full-width compares, one extra bit so ENTRIES == 2**A still works.
    assign lk_hit = ({1'b0, lookup_addr} < (A + 1)'(ENTRIES));
    assign lk_go  = in_run && lookup_req && !clr;
    assign wr_go  = in_run && wr_en && !clr && (wr_addr != '0)
                    && ({1'b0, wr_addr} < (A + 1)'(ENTRIES));

    // Write-first: a lookup hitting the address written this cycle sees the new data.
    assign bypass = wr_go && (wr_addr == lookup_addr);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    if (sweep_done) state_d = RUN;
            RUN:     if (clr)        state_d = INIT;
            default: state_d = INIT;
        endcase
    end

    // Single table write port: sweep in INIT, external writes in RUN.
    always_comb begin
        tbl_we   = 1'b0;
        tbl_widx = '0;
        tbl_wval = '0;
        if (state_q == INIT) begin
            tbl_we   = 1'b1;
            tbl_widx = idx;
            tbl_wval = (idx == '0) ? '0 : D'(DEF_TARGET);
        end else if (wr_go) begin
            tbl_we   = 1'b1;
            tbl_widx = wr_addr[IW-1:0];
            tbl_wval = wr_data;
        end
    end

    always_comb begin
        rd_val = D'(PC_HOLD);
        if (lk_hit) begin
            rd_val = bypass ? wr_data : tbl[lookup_addr[IW-1:0]];
        end
    end

    always_ff @(posedge Clk) begin
        if (tbl_we) begin
            tbl[tbl_widx] <= tbl_wval;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q        <= INIT;
            target_q       <= '0;
            target_valid_q <= 1'b0;
            hit_q          <= 1'b0;
            wr_ack_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_valid_q <= lk_go;
            wr_ack_q       <= wr_go;
            if (lk_go) begin
                target_q <= rd_val;
                hit_q    <= lk_hit;
            end
        end
    end

    assign target       = target_q;
    assign target_valid = target_valid_q;
    assign hit          = hit_q;
    assign wr_ack       = wr_ack_q;
    assign busy         = (state_q == INIT);

endmodule

// File: tb/tb_pc_target_table.sv
module tb_pc_target_table;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        lookup_req = 1'b0;
    logic [7:0]  lookup_addr = '0;
    logic [11:0] target;
    logic        target_valid;
    logic        hit;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        wr_ack;
    logic        clr = 1'b0;
    logic        busy;

    pc_target_table #(
        .D          (12),
        .A          (8),
        .ENTRIES    (16),
        .DEF_TARGET (1)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .lookup_req   (lookup_req),
        .lookup_addr  (lookup_addr),
        .target       (target),
        .target_valid (target_valid),
        .hit          (hit),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .clr          (clr),
        .busy         (busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int unsigned due;
        logic        v;
        logic [11:0] t;
        logic        h;
    } lk_exp_t;

    typedef struct {
        int unsigned due;
        logic        a;
    } wr_exp_t;

    lk_exp_t     lk_q[$];
    wr_exp_t     wr_q[$];
    int unsigned edges = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs against the scoreboard whenever an expectation is due,
    // and flags any response pulse that nothing asked for.
    initial begin
        lk_exp_t le;
        wr_exp_t we;
        forever begin
            @(posedge Clk);
            edges++;
            #1;
            if (lk_q.size() > 0 && lk_q[0].due == edges) begin
                le = lk_q.pop_front();
                chk("lk_valid", 32'(target_valid), 32'(le.v));
                if (le.v) begin
                    chk("lk_target", 32'(target), 32'(le.t));
                    chk("lk_hit", 32'(hit), 32'(le.h));
                end
            end else if (target_valid) begin
                chk("unexpected_valid", 32'(target_valid), 32'd0);
            end
            if (wr_q.size() > 0 && wr_q[0].due == edges) begin
                we = wr_q.pop_front();
                chk("wr_ack", 32'(wr_ack), 32'(we.a));
            end else if (wr_ack) begin
                chk("unexpected_ack", 32'(wr_ack), 32'd0);
            end
        end
    end

    task automatic step(input logic lk, input logic [7:0] la, input logic we,
                        input logic [7:0] wa, input logic [11:0] wd, input logic c,
                        input logic ev, input logic [11:0] et, input logic eh,
                        input logic ea);
        lk_exp_t le;
        wr_exp_t wx;
        @(negedge Clk);
        lookup_req  = lk;
        lookup_addr = la;
        wr_en       = we;
        wr_addr     = wa;
        wr_data     = wd;
        clr         = c;
        if (lk) begin
            le.due = edges + 1; le.v = ev; le.t = et; le.h = eh;
            lk_q.push_back(le);
        end
        if (we) begin
            wx.due = edges + 1; wx.a = ea;
            wr_q.push_back(wx);
        end
    endtask

    task automatic lookup(input logic [7:0] la, input logic [11:0] et, input logic eh);
        step(1'b1, la, 1'b0, 8'd0, 12'd0, 1'b0, 1'b1, et, eh, 1'b0);
    endtask

    task automatic write(input logic [7:0] wa, input logic [11:0] wd, input logic ea);
        step(1'b0, 8'd0, 1'b1, wa, wd, 1'b0, 1'b0, 12'd0, 1'b0, ea);
    endtask

    task automatic idle();
        @(negedge Clk);
        lookup_req = 1'b0;
        wr_en      = 1'b0;
        clr        = 1'b0;
    endtask

    // Counts rising edges until busy reads low; an expired budget reads as a wrong length.
    task automatic wait_sweep(input int exp);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge Clk);
            #1;
            n++;
            if (!busy) done = 1;
        end
        chk("sweep_len", 32'(n), 32'(exp));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_target"}, 32'(target), 32'd0);
        chk({tag, "_valid"}, 32'(target_valid), 32'd0);
        chk({tag, "_hit"}, 32'(hit), 32'd0);
        chk({tag, "_ack"}, 32'(wr_ack), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        // Power-on reset.
        #1 Reset = 1'b0;
        #1 chk_reset_outputs("por");
        @(negedge Clk) Reset = 1'b1;

        // Reset hit at sweep cycle 7: the sweep must restart from scratch.
        repeat (7) @(posedge Clk);
        #2 Reset = 1'b0;
        #1 chk_reset_outputs("sweep_rst");
        @(negedge Clk) Reset = 1'b1;
        wait_sweep(16);

        // Default map and range boundaries.
        lookup(8'd0, 12'd0, 1'b1);
        lookup(8'd5, 12'd1, 1'b1);
        lookup(8'd15, 12'd1, 1'b1);
        lookup(8'd16, 12'd0, 1'b0);
        idle();

        // Writes, read-back and write-first bypass.
        write(8'd3, 12'd54, 1'b1);
        lookup(8'd3, 12'd54, 1'b1);
        step(1'b1, 8'd4, 1'b1, 8'd4, 12'd76, 1'b0, 1'b1, 12'd76, 1'b1, 1'b1);
        idle();

        // Dropped writes to the read-only entry and out of range.
        write(8'd0, 12'd17, 1'b0);
        write(8'd20, 12'd9, 1'b0);
        lookup(8'd0, 12'd0, 1'b1);
        lookup(8'd20, 12'd0, 1'b0);
        idle();

        // Back-to-back lookups.
        write(8'd1, 12'd17, 1'b1);
        write(8'd2, 12'd30, 1'b1);
        lookup(8'd1, 12'd17, 1'b1);
        lookup(8'd2, 12'd30, 1'b1);
        lookup(8'd3, 12'd54, 1'b1);
        idle();

        // clr beats a same-cycle write and lookup.
        step(1'b1, 8'd2, 1'b1, 8'd2, 12'd88, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0);
        @(posedge Clk);
        #1 chk("clr_busy", 32'(busy), 32'd1);
        idle();
        wait_sweep(16);
        lookup(8'd2, 12'd1, 1'b1);
        lookup(8'd4, 12'd1, 1'b1);
        idle();

        // Reset mid-RUN with a lookup pending.
        write(8'd3, 12'd91, 1'b1);
        lookup(8'd3, 12'd91, 1'b1);
        @(negedge Clk);
        lookup_req  = 1'b1;
        lookup_addr = 8'd3;
        #2 Reset = 1'b0;
        #1 chk_reset_outputs("run_rst");
        lookup_req = 1'b0;
        lk_q.delete();
        wr_q.delete();
        @(negedge Clk) Reset = 1'b1;
        wait_sweep(16);
        lookup(8'd3, 12'd1, 1'b1);
        idle();

        repeat (3) @(negedge Clk);
        chk("drain_lk", 32'(lk_q.size()), 32'd0);
        chk("drain_wr", 32'(wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_target_table.md
# pc_target_table

Programmable successor to the fixed branch-target lookup. It holds `ENTRIES` absolute jump targets of width `D`, indexed by the branch-instruction operand. After reset it self-initialises to the default map: entry 0 = 0, all others = `DEF_TARGET`. Entries can be rewritten at run time through a write port, and lookups return a registered result one cycle later. It sits between instruction decode (address source) and the PC register (target consumer).

## Interface
Parameters:
- `D`, 12, target/PC width
- `A`, 8, lookup/write address width
- `ENTRIES`, 16, number of table entries (≤ 2^A)
- `DEF_TARGET`, 1, init value of entries 1..ENTRIES-1

Ports:
- `Clk`  in  1  system clock, all state on rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `lookup_req`  in  1  lookup strobe
- `lookup_addr`  in  A  lookup index
- `target`  out  D  looked-up target, registered
- `target_valid`  out  1  one-cycle pulse: `target`/`hit` valid
- `hit`  out  1  index was < ENTRIES
- `wr_en`  in  1  write strobe
- `wr_addr`  in  A  write index
- `wr_data`  in  D  write value
- `wr_ack`  out  1  one-cycle pulse: write accepted
- `clr`  in  1  re-initialise table to default map
- `busy`  out  1  init sweep in progress

## Operation
- States: INIT, RUN. Reset forces INIT and `idx`=0.
- INIT:
  - One entry written per cycle: entry `idx` ← (`idx`==0 ? 0 : DEF_TARGET).
  - `idx` increments each cycle. After writing ENTRIES-1 → RUN.
  - `busy`=1 throughout.
  - `lookup_req`, `wr_en` and `clr` are ignored; no `target_valid` or `wr_ack` is produced.
- RUN, lookup:
  - `lookup_req`=1 → next cycle `target_valid`=1.
  - If `lookup_addr`<ENTRIES: `hit`=1 and `target`=table[addr].
  - Otherwise: `hit`=0 and `target`=0 (hold-PC semantics).
- RUN, write:
  - `wr_en`=1 with 0 < `wr_addr` < ENTRIES → entry updated; next cycle `wr_ack`=1.
  - `wr_addr`=0 (read-only entry) or ≥ENTRIES → write dropped, `wr_ack`=0.
- Same-cycle write + lookup to the same accepted address → lookup returns `wr_data` (write-first bypass).
- RUN, `clr`=1 → INIT, `idx`=0 next cycle.
  - `clr` takes priority: a same-cycle write is dropped (`wr_ack`=0) and a same-cycle lookup is dropped (`target_valid`=0).
- `wr_data` wider values are not possible. `lookup_addr`/`wr_addr` compare is unsigned, full A bits, no wrap-around.

## Timing
- All outputs are registered.
- Reset values: `target`=0, `target_valid`=0, `hit`=0, `wr_ack`=0, `busy`=1.
- Reset assertion takes effect immediately, mid-sweep or mid-RUN. Table contents are then undefined until the sweep completes.
- After reset release, `busy` stays 1 for exactly ENTRIES rising edges, then drops. The first lookup is accepted on the cycle `busy` reads 0.
- Lookup latency is 1 cycle, with back-to-back requests every cycle. Write ack latency is 1 cycle.
- `clr` → `busy`=1 on the next cycle, for ENTRIES cycles.

## Structure
- Shared package `pc_pkg`: `pc_t` (logic [D-1:0]), `tt_state_e` {INIT, RUN}, `PC_HOLD`=0.
- Storage: flop array `pc_t tbl[ENTRIES]` with a single write port. The write-port mux selects between the sweep write and the external write.
- Optional sub-module `pc_tt_init_ctr`: sweep counter with `done` flag. No other sub-modules.

## Test plan
- Reset release, defaults D=12, ENTRIES=16 → `busy` high 16 cycles. Then lookup addr 0 → target 0, hit 1; addr 5 → target 1, hit 1.
- Write addr 3 = 54 → `wr_ack` pulse. Lookup 3 next cycle → target 54. Same-cycle write 4=76 + lookup 4 → target 76.
- Write addr 0 = 17 and addr 20 = 9 → no `wr_ack`. Lookup 0 → 0, hit 1; lookup 20 → target 0, hit 0.
- Lookups to 1,2,3 on consecutive cycles after writing 17,30,54 → `target_valid` on three consecutive cycles, targets 17,30,54.
- `clr` with same-cycle write 2=88 → no ack, `busy` 16 cycles, then lookup 2 → 1.
- Reset asserted at sweep cycle 7 and again mid-RUN with `lookup_req` pending → all outputs to reset values within the same cycle. Full 16-cycle sweep after release; a prior write of 3=91 reads back 1.
